// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd1;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: {valid, pc, instr}.
// Priority is flush, then load, then stall (hold); otherwise a bubble is inserted.
module if_id_reg #(
    parameter int PC_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [31:0]     instr_i,
    output logic            valid_o,
    output logic [PC_W-1:0] pc_o,
    output logic [31:0]     instr_o
);

    logic            valid_q, valid_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;

    // Next-state selection for the pipeline register.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Register update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word read at a
// time, and feeds the IF/ID register with stall (skid buffer) and redirect.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] bj_target,
    input  logic            pc_bj,
    input  logic            stall,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_instr
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
    logic            drop_q, drop_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;

    logic            id_load_s;
    logic            id_flush_s;
    logic [PC_W-1:0] id_pc_in_s;
    logic [31:0]     id_instr_in_s;
    logic [PC_W-1:0] seq_pc_s;

    assign seq_pc_s = inflight_pc_q + PC_W'(PC_INC);

    // Fetch FSM: next state, PC, drop flag, skid buffer and IF/ID load controls.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        drop_d        = drop_q;
        skid_pc_d     = skid_pc_q;
        skid_instr_d  = skid_instr_q;
        id_load_s     = 1'b0;
        id_flush_s    = 1'b0;
        id_pc_in_s    = inflight_pc_q;
        id_instr_in_s = imem_rdata;
        case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_ready) begin
                    inflight_pc_d = pc_q;
                    state_d       = WAIT;
                end else begin
                    state_d = REQ;
                end
                if (pc_bj) begin
                    pc_d       = bj_target;
                    id_flush_s = 1'b1;
                    // The old-address request already left; its reply must be discarded.
                    drop_d     = imem_ready;
                end else begin
                    pc_d = pc_q;
                end
            end
            WAIT: begin
                if (pc_bj) begin
                    pc_d       = bj_target;
                    id_flush_s = 1'b1;
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else if (!stall || !id_valid) begin
                        id_load_s = 1'b1;
                        pc_d      = seq_pc_s;
                        state_d   = REQ;
                    end else begin
                        skid_pc_d    = inflight_pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                id_pc_in_s    = skid_pc_q;
                id_instr_in_s = skid_instr_q;
                if (pc_bj) begin
                    pc_d       = bj_target;
                    id_flush_s = 1'b1;
                    state_d    = REQ;
                end else if (!stall) begin
                    id_load_s = 1'b1;
                    pc_d      = seq_pc_s;
                    state_d   = REQ;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC and skid buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= PC_W'(RESET_PC);
            inflight_pc_q <= PC_W'(RESET_PC);
            drop_q        <= 1'b0;
            skid_pc_q     <= '0;
            skid_instr_q  <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            drop_q        <= drop_d;
            skid_pc_q     <= skid_pc_d;
            skid_instr_q  <= skid_instr_d;
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;

    if_id_reg #(
        .PC_W (PC_W)
    ) u_if_id_reg (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (id_load_s),
        .stall_i (stall),
        .flush_i (id_flush_s),
        .pc_i    (id_pc_in_s),
        .instr_i (id_instr_in_s),
        .valid_o (id_valid),
        .pc_o    (id_pc),
        .instr_o (id_instr)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage with a one-outstanding memory model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] bj_target;
    logic        pc_bj;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    int          chk_cnt = 0;
    int          err_cnt = 0;
    logic        pend;
    logic [31:0] pend_addr;
    logic        mem_hold;

    if_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .PC_W     (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bj_target   (bj_target),
        .pc_bj       (pc_bj),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record acceptance before the edge, present the response after it.
    task automatic tick();
        logic        acc;
        logic [31:0] acc_addr;
        acc      = imem_req && imem_ready;
        acc_addr = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = acc_addr;
        end
        if (pend && !mem_hold) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(pend_addr);
            pend        = 1'b0;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bj_target   = 32'h0;
        pc_bj       = 1'b0;
        stall       = 1'b0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        pend        = 1'b0;
        pend_addr   = 32'h0;
        mem_hold    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, id_valid}, 32'd0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch with a zero-wait memory.
        check("boot_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
        tick();
        check("wait_req", {31'd0, imem_req}, 32'd0);
        check("wait_valid", {31'd0, id_valid}, 32'd0);
        tick();
        check("seq0_valid", {31'd0, id_valid}, 32'd1);
        check("seq0_pc", id_pc, 32'h0);
        check("seq0_instr", id_instr, instr_of(32'h0));
        check("seq_addr1", imem_addr, 32'h1);
        tick();
        check("seq_bubble", {31'd0, id_valid}, 32'd0);
        tick();
        check("seq1_valid", {31'd0, id_valid}, 32'd1);
        check("seq1_pc", id_pc, 32'h1);
        check("seq_addr2", imem_addr, 32'h2);

        // Redirect while waiting with no response yet.
        mem_hold = 1'b1;
        tick();
        pc_bj     = 1'b1;
        bj_target = 32'h40;
        tick();
        pc_bj    = 1'b0;
        check("bj_wait_valid", {31'd0, id_valid}, 32'd0);
        check("bj_wait_req", {31'd0, imem_req}, 32'd0);
        mem_hold = 1'b0;
        tick();
        check("bj_drop_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("bj_target_req", {31'd0, imem_req}, 32'd1);
        check("bj_target_addr", imem_addr, 32'h40);
        check("bj_drop_valid", {31'd0, id_valid}, 32'd0);
        tick();
        tick();
        check("bj_id_pc", id_pc, 32'h40);
        check("bj_id_instr", id_instr, instr_of(32'h40));
        check("bj_id_valid", {31'd0, id_valid}, 32'd1);
        check("bj_next_addr", imem_addr, 32'h41);

        // Stall for three cycles while the response arrives.
        stall = 1'b1;
        tick();
        check("st1_pc", id_pc, 32'h40);
        tick();
        check("st2_pc", id_pc, 32'h40);
        check("st2_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("st3_pc", id_pc, 32'h40);
        check("st3_instr", id_instr, instr_of(32'h40));
        check("st3_valid", {31'd0, id_valid}, 32'd1);
        stall = 1'b0;
        tick();
        check("unst_pc", id_pc, 32'h41);
        check("unst_instr", id_instr, instr_of(32'h41));
        check("unst_addr", imem_addr, 32'h42);
        check("unst_req", {31'd0, imem_req}, 32'd1);

        // Redirect and stall together while holding a skid entry.
        stall = 1'b1;
        tick();
        tick();
        pc_bj     = 1'b1;
        bj_target = 32'h100;
        tick();
        pc_bj = 1'b0;
        stall = 1'b0;
        check("hold_bj_valid", {31'd0, id_valid}, 32'd0);
        check("hold_bj_req", {31'd0, imem_req}, 32'd1);
        check("hold_bj_addr", imem_addr, 32'h100);
        tick();
        tick();
        check("hold_bj_id_pc", id_pc, 32'h100);

        // Redirect accepted in REQ, then PC wrap at the top of the address space.
        pc_bj     = 1'b1;
        bj_target = 32'hFFFF_FFFF;
        tick();
        pc_bj = 1'b0;
        check("req_bj_req", {31'd0, imem_req}, 32'd0);
        check("req_bj_valid", {31'd0, id_valid}, 32'd0);
        tick();
        check("req_bj_addr", imem_addr, 32'hFFFF_FFFF);
        check("req_bj_drop_valid", {31'd0, id_valid}, 32'd0);
        tick();
        tick();
        check("wrap_id_pc", id_pc, 32'hFFFF_FFFF);
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset during WAIT; a late response during BOOT must be ignored.
        mem_hold = 1'b1;
        tick();
        rst_n = 1'b0;
        pend  = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'd0, id_valid}, 32'd0);
        check("mid_rst_id_pc", id_pc, 32'h0);
        mem_hold    = 1'b0;
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        check("late_req", {31'd0, imem_req}, 32'd1);
        check("late_addr", imem_addr, 32'h0);
        check("late_valid", {31'd0, id_valid}, 32'd0);
        tick();
        tick();
        check("restart_pc", id_pc, 32'h0);
        check("restart_instr", id_instr, instr_of(32'h0));
        check("restart_valid", {31'd0, id_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
